// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg : shared types/constants for the pipeline hazard controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    PC_IDLE     = 1'b0,
    PC_MUL_BUSY = 1'b1
  } pc_state_e;

  localparam int unsigned PC_CNT_W_DEFAULT = 32;
  localparam logic [4:0]  ZERO_REG         = 5'd0;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_perf_sat_counter.sv
// ---------------------------------------------------------------------------
// perf_sat_counter : saturating event counter with synchronous clear
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module perf_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : stall/bubble/flush sequencing for MUL, branch, load-use
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned CNT_W       = PC_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_id_valid,
  input  logic [4:0]       id_rs1_idx,
  input  logic [4:0]       id_rs2_idx,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_ex_valid,
  input  logic             id_ex_rd_mem,
  input  logic             id_ex_is_mul,
  input  logic [4:0]       id_ex_dest_idx,
  input  logic             ex_take_branch,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             ex_mem_bubble,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  pc_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hold;
  logic       done;
  logic       load_use_raw;
  logic       flush;
  logic       load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PC_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (MUL_LATENCY >= 2) begin : g_mul_multi
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        done    = 1'b0;
        case (state_q)
          PC_IDLE: begin
            if (id_ex_valid && id_ex_is_mul) begin
              hold    = 1'b1;
              cnt_d   = 4'(MUL_LATENCY - 2);
              state_d = PC_MUL_BUSY;
            end
          end
          PC_MUL_BUSY: begin
            if (cnt_q != 4'd0) begin
              hold  = 1'b1;
              cnt_d = cnt_q - 4'd1;
            end else begin
              done    = 1'b1;
              state_d = PC_IDLE;
            end
          end
          default: state_d = PC_IDLE;
        endcase
      end
    end else begin : g_mul_single
      // Single-cycle multiply never holds EX; completion is flagged in place.
      always_comb begin
        state_d = PC_IDLE;
        cnt_d   = 4'd0;
        hold    = 1'b0;
        done    = (state_q == PC_IDLE) && id_ex_valid && id_ex_is_mul && (cnt_q == 4'd0);
      end
    end
  endgenerate

  assign load_use_raw = if_id_valid && id_ex_valid && id_ex_rd_mem &&
                        (id_ex_dest_idx != ZERO_REG) &&
                        ((id_uses_rs1 && (id_rs1_idx == id_ex_dest_idx)) ||
                         (id_uses_rs2 && (id_rs2_idx == id_ex_dest_idx)));

  assign flush    = id_ex_valid && ex_take_branch && !hold;
  assign load_use = load_use_raw && !hold && !flush;

  // Outputs are forced low while reset is held, independent of the inputs.
  assign pc_stall      = rst && (hold || load_use);
  assign if_id_stall   = rst && (hold || load_use);
  assign id_ex_stall   = rst && hold;
  assign id_ex_bubble  = rst && (flush || load_use);
  assign if_id_flush   = rst && flush;
  assign ex_mem_bubble = rst && hold;
  assign mul_done      = rst && done;

  perf_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .clr   (perf_clr),
    .value (stall_cycles)
  );

  perf_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_id_flush),
    .clr   (perf_clr),
    .value (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed vectors with a per-cycle expectation queue
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam logic [6:0] Z    = 7'b0000000;
  localparam logic [6:0] HOLD = 7'b1110010;
  localparam logic [6:0] DONE = 7'b0000001;
  localparam logic [6:0] LU   = 7'b1101000;
  localparam logic [6:0] FL   = 7'b0001100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       if_id_valid = 1'b0;
  logic [4:0] id_rs1_idx = 5'd0;
  logic [4:0] id_rs2_idx = 5'd0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic       id_ex_valid = 1'b0;
  logic       id_ex_rd_mem = 1'b0;
  logic       id_ex_is_mul = 1'b0;
  logic [4:0] id_ex_dest_idx = 5'd0;
  logic       ex_take_branch = 1'b0;
  logic       perf_clr = 1'b0;
  logic       pc_stall, if_id_stall, id_ex_stall, id_ex_bubble;
  logic       if_id_flush, ex_mem_bubble, mul_done;
  logic [3:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.MUL_LATENCY(3), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_id_valid    (if_id_valid),
    .id_rs1_idx     (id_rs1_idx),
    .id_rs2_idx     (id_rs2_idx),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_ex_valid    (id_ex_valid),
    .id_ex_rd_mem   (id_ex_rd_mem),
    .id_ex_is_mul   (id_ex_is_mul),
    .id_ex_dest_idx (id_ex_dest_idx),
    .ex_take_branch (ex_take_branch),
    .perf_clr       (perf_clr),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .id_ex_stall    (id_ex_stall),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .ex_mem_bubble  (ex_mem_bubble),
    .mul_done       (mul_done),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [6:0] ctrl;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;
  logic [3:0] sc_m = 4'd0;
  logic [3:0] fc_m = 4'd0;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble,
             if_id_flush, ex_mem_bubble, mul_done};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl vec=%0d got=%b want=%b", e.id, act, e.ctrl);
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL stall_cycles vec=%0d got=%0d want=%0d", e.id, stall_cycles, e.sc);
      end
      checks++;
      if (flush_count !== e.fc) begin
        errors++;
        $display("FAIL flush_count vec=%0d got=%0d want=%0d", e.id, flush_count, e.fc);
      end
    end
  end

  task automatic vec(input logic r, input logic ifv, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic exv, input logic rdm, input logic mul,
                     input logic [4:0] dst, input logic br, input logic clr,
                     input logic [6:0] ctrl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; if_id_valid = ifv; id_rs1_idx = rs1; id_rs2_idx = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_ex_valid = exv; id_ex_rd_mem = rdm;
    id_ex_is_mul = mul; id_ex_dest_idx = dst; ex_take_branch = br; perf_clr = clr;
    e.id   = vec_id;
    e.ctrl = ctrl;
    e.sc   = r ? sc_m : 4'd0;
    e.fc   = r ? fc_m : 4'd0;
    sb.push_back(e);
    vec_id++;
    if (!r || clr) begin
      sc_m = 4'd0;
      fc_m = 4'd0;
    end else begin
      if (ctrl[6] && sc_m != 4'hF) sc_m = sc_m + 4'd1;
      if (ctrl[2] && fc_m != 4'hF) fc_m = fc_m + 4'd1;
    end
  endtask

  task automatic idle_v(input logic r, input logic clr);
    vec(r, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, clr, Z);
  endtask

  task automatic mul_v(input logic r, input logic [6:0] ctrl);
    vec(r, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, ctrl);
  endtask

  // ID holds add x6,x5,x7; ID/EX holds a load to x5.
  task automatic lu_v(input logic br, input logic clr, input logic [6:0] ctrl);
    vec(1'b1, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, br, clr, ctrl);
  endtask

  initial begin
    idle_v(1'b0, 1'b0);
    idle_v(1'b0, 1'b0);

    // Single MUL, latency 3
    mul_v(1'b1, HOLD);
    mul_v(1'b1, HOLD);
    mul_v(1'b1, DONE);
    idle_v(1'b1, 1'b0);

    // Load-use variants
    lu_v(1'b0, 1'b0, LU);
    idle_v(1'b1, 1'b0);
    vec(1'b1, 1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, Z);
    vec(1'b1, 1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, LU);
    vec(1'b1, 1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, Z);
    vec(1'b1, 1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, Z);
    vec(1'b1, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, Z);

    // Branch beats load-use
    lu_v(1'b1, 1'b0, FL);
    idle_v(1'b1, 1'b0);

    // Back-to-back MULs from a cleared counter
    idle_v(1'b1, 1'b1);
    mul_v(1'b1, HOLD);
    mul_v(1'b1, HOLD);
    mul_v(1'b1, DONE);
    mul_v(1'b1, HOLD);
    mul_v(1'b1, HOLD);
    mul_v(1'b1, DONE);
    idle_v(1'b1, 1'b0);

    // Reset during MUL_BUSY, then restart with the MUL still present
    mul_v(1'b1, HOLD);
    mul_v(1'b0, Z);
    mul_v(1'b1, HOLD);
    mul_v(1'b1, HOLD);
    mul_v(1'b1, DONE);
    idle_v(1'b1, 1'b0);

    // Saturation at 15, then clear on a stall cycle
    idle_v(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) lu_v(1'b0, 1'b0, LU);
    lu_v(1'b0, 1'b1, LU);
    idle_v(1'b1, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
